mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4-input resource port, such as the shared memory/bus path fed through the 4:1 datapath multiplexer, among four requesters. It accepts per-requester request lines and issues a registered one-hot grant. It drives the multiplexer select directly from the grant and rotates priority after every grant. An optional hold limit preempts a requester that monopolises the resource while others wait.

---
 rtl/mux4_rr_arbiter_pkg.sv | 22 ++
 rtl/mux4_rr_arbiter_pick.sv | 29 ++
 rtl/mux4_rr_arbiter.sv | 112 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types for the 4-way round-robin arbiter and the datapath mux it steers.
// The mux select and the arbiter's grant index share sel_t.
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] sel_onehot(input sel_t sel);
        sel_onehot = 4'b0001 << sel;
    endfunction

    function automatic sel_t sel_next(input sel_t sel);
        sel_next = sel + 2'd1;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// rr_pick4: finds the first set bit of a 4-bit request mask, searching
// ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  sel_t               ptr,
    output logic               found,
    output sel_t               idx
);

    sel_t cand_s;
    logic hit_s;

    // Priority search starting at ptr; first hit wins.
    always_comb begin
        found  = 1'b0;
        idx    = ptr;
        cand_s = ptr;
        hit_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = ptr + sel_t'(i);
            hit_s  = !found && req[cand_s];
            idx    = hit_s ? cand_s : idx;
            found  = found | hit_s;
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4-input port: registered one-hot grant,
// mux select, and optional hold-limit preemption.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    input  logic [NUM_REQ-1:0] i_Request,
    output logic [NUM_REQ-1:0] o_Grant,
    output sel_t               o_Select,
    output logic               o_Valid,
    output logic               o_Preempt
);

    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic          HOLD_EN   = (MAX_HOLD > 0);

    state_t          state_r, state_s;
    sel_t            ptr_r, ptr_s;
    sel_t            sel_r, sel_s;
    logic [CW-1:0]   hold_r, hold_s;
    logic            preempt_r, preempt_s;

    logic               owner_req_s;
    logic [NUM_REQ-1:0] others_s;
    logic [NUM_REQ-1:0] pick_mask_s;
    logic               pick_found_s;
    sel_t               pick_idx_s;
    logic               limit_hit_s;

    assign owner_req_s = i_Request[sel_r];
    assign others_s    = i_Request & ~sel_onehot(sel_r);
    // While busy the owner is masked out so handover and preemption look past it.
    assign pick_mask_s = (state_r == BUSY) ? others_s : i_Request;
    assign limit_hit_s = HOLD_EN && (hold_r == HOLD_LAST);

    rr_pick4 u_pick (
        .req   (pick_mask_s),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Next-state: grant, handover, preemption and hold counting.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        sel_s     = sel_r;
        hold_s    = hold_r;
        preempt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_s = BUSY;
                    sel_s   = pick_idx_s;
                    ptr_s   = sel_next(pick_idx_s);
                    hold_s  = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (!owner_req_s) begin
                    if (pick_found_s) begin
                        sel_s  = pick_idx_s;
                        ptr_s  = sel_next(pick_idx_s);
                        hold_s = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (limit_hit_s && pick_found_s) begin
                    sel_s     = pick_idx_s;
                    ptr_s     = sel_next(pick_idx_s);
                    hold_s    = '0;
                    preempt_s = 1'b1;
                end else begin
                    hold_s = (hold_r == HOLD_MAX) ? hold_r : hold_r + 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, pointer, select, hold counter and preempt pulse registers.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_r   <= IDLE;
            ptr_r     <= 2'd0;
            sel_r     <= 2'd0;
            hold_r    <= '0;
            preempt_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            sel_r     <= sel_s;
            hold_r    <= hold_s;
            preempt_r <= preempt_s;
        end
    end

    assign o_Grant   = (state_r == BUSY) ? sel_onehot(sel_r) : 4'b0000;
    assign o_Select  = sel_r;
    assign o_Valid   = (state_r == BUSY);
    assign o_Preempt = preempt_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: three arbiters (MAX_HOLD 4, 16, 0) share one request
// stream and are compared against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant_s [3];
    logic [1:0] sel_s   [3];
    logic       valid_s [3];
    logic       pre_s   [3];

    int n_cmp;
    int n_bad;

    localparam int MH [3] = '{4, 16, 0};

    // Model state per instance: owner (-1 idle), next-priority index,
    // cycles the owner has been granted, last select, preempt pulse.
    int m_owner [3];
    int m_prio  [3];
    int m_held  [3];
    int m_sel   [3];
    int m_pre   [3];

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .i_Clock(clk), .i_Reset(rst_n), .i_Request(req),
        .o_Grant(grant_s[0]), .o_Select(sel_s[0]), .o_Valid(valid_s[0]), .o_Preempt(pre_s[0])
    );
    mux4_rr_arbiter dut16 (
        .i_Clock(clk), .i_Reset(rst_n), .i_Request(req),
        .o_Grant(grant_s[1]), .o_Select(sel_s[1]), .o_Valid(valid_s[1]), .o_Preempt(pre_s[1])
    );
    mux4_rr_arbiter #(.MAX_HOLD(0)) dut0 (
        .i_Clock(clk), .i_Reset(rst_n), .i_Request(req),
        .o_Grant(grant_s[2]), .o_Select(sel_s[2]), .o_Valid(valid_s[2]), .o_Preempt(pre_s[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] m, input int p);
        for (int i = 0; i < 4; i++) begin
            if (m[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_owner[d] = -1; m_prio[d] = 0; m_held[d] = 0; m_sel[d] = 0; m_pre[d] = 0;
        end
    endtask

    task automatic grant_to(input int d, input int who);
        m_owner[d] = who;
        m_sel[d]   = who;
        m_prio[d]  = (who + 1) % 4;
        m_held[d]  = 1;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] others;
        for (int d = 0; d < 3; d++) begin
            m_pre[d] = 0;
            if (m_owner[d] < 0) begin
                if (r != 4'b0000) grant_to(d, pick(r, m_prio[d]));
            end else begin
                others = r;
                others[m_owner[d]] = 1'b0;
                if (!r[m_owner[d]]) begin
                    if (others != 4'b0000) grant_to(d, pick(others, m_prio[d]));
                    else m_owner[d] = -1;
                end else if (MH[d] != 0 && m_held[d] == MH[d] && others != 4'b0000) begin
                    grant_to(d, pick(others, m_prio[d]));
                    m_pre[d] = 1;
                end else begin
                    m_held[d] = (m_held[d] > MH[d]) ? m_held[d] : m_held[d] + 1;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_vec(input int d);
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner[d] >= 0) g[m_owner[d]] = 1'b1;
        return {g, 2'(m_sel[d]), (m_owner[d] >= 0), (m_pre[d] != 0)};
    endfunction

    function automatic logic [7:0] obs_vec(input int d);
        return {grant_s[d], sel_s[d], valid_s[d], pre_s[d]};
    endfunction

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        #12;
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs_vec(d) !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got %b expected %b", d, obs_vec(d), 8'h00);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0100);
        n_cmp++;
        if (obs_vec(0) !== 8'b0100_10_1_0) begin
            n_bad++;
            $display("FAIL reset_pre_busy: got %b expected %b", obs_vec(0), 8'b0100_10_1_0);
        end
        #2;
        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs_vec(d) !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_async dut%0d: got %b expected %b", d, obs_vec(d), 8'h00);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0001;
        @(posedge clk);
        model_step(4'b0001);
        #1;
        exp = 8'b0001_00_1_0;
        n_cmp++;
        if (obs_vec(0) !== exp) begin
            n_bad++;
            $display("FAIL reset_restart: got %b expected %b", obs_vec(0), exp);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp;
        int         slot;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(4'b1111);
            slot = (k / 4) % 4;
            exp  = {4'b0001 << slot, 2'(slot), 1'b1, (k > 0 && k % 4 == 0)};
            n_cmp++;
            if (obs_vec(0) !== exp) begin
                n_bad++;
                $display("FAIL rotation cyc%0d: got %b expected %b", k, obs_vec(0), exp);
            end
        end
    endtask

    task automatic test_handover();
        do_reset();
        step(4'b0100);
        n_cmp++;
        if (obs_vec(0) !== 8'b0100_10_1_0) begin
            n_bad++;
            $display("FAIL handover_first: got %b expected %b", obs_vec(0), 8'b0100_10_1_0);
        end
        step(4'b1001);
        n_cmp++;
        if (obs_vec(0) !== 8'b1000_11_1_0) begin
            n_bad++;
            $display("FAIL handover_next: got %b expected %b", obs_vec(0), 8'b1000_11_1_0);
        end
    endtask

    task automatic test_single_hold();
        do_reset();
        for (int k = 0; k < 100; k++) begin
            step(4'b0010);
            n_cmp++;
            if (obs_vec(1) !== 8'b0010_01_1_0) begin
                n_bad++;
                $display("FAIL single_hold cyc%0d: got %b expected %b", k, obs_vec(1), 8'b0010_01_1_0);
            end
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        for (int k = 0; k < 50; k++) begin
            step(4'b0011);
            n_cmp++;
            if (obs_vec(2) !== 8'b0001_00_1_0) begin
                n_bad++;
                $display("FAIL no_preempt cyc%0d: got %b expected %b", k, obs_vec(2), 8'b0001_00_1_0);
            end
        end
        step(4'b0010);
        n_cmp++;
        if (obs_vec(2) !== 8'b0010_01_1_0) begin
            n_bad++;
            $display("FAIL no_preempt_drop: got %b expected %b", obs_vec(2), 8'b0010_01_1_0);
        end
    endtask

    task automatic test_drop_at_limit();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(4'b0011);
            n_cmp++;
            if (obs_vec(0) !== 8'b0001_00_1_0) begin
                n_bad++;
                $display("FAIL limit_hold cyc%0d: got %b expected %b", k, obs_vec(0), 8'b0001_00_1_0);
            end
        end
        step(4'b0010);
        n_cmp++;
        if (obs_vec(0) !== 8'b0010_01_1_0) begin
            n_bad++;
            $display("FAIL limit_drop: got %b expected %b", obs_vec(0), 8'b0010_01_1_0);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        do_reset();
        r = 4'b0000;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < 4; b++) begin
                if (r[b]) r[b] = ($urandom_range(0, 5) != 0);
                else      r[b] = ($urandom_range(0, 3) == 0);
            end
            step(r);
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_bad++;
                    $display("FAIL random dut%0d cyc%0d req=%b: got %b expected %b",
                             d, k, r, obs_vec(d), exp_vec(d));
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_rotation();
        test_handover();
        test_single_hold();
        test_no_preempt();
        test_drop_at_limit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
